// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - valid/ready output stream of the FIFO drain stage
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains synch_fifo through a 3-entry buffer onto a valid/ready stream
// Reads are issued from registered state only, so out_ready never reaches the FIFO controls.
module fifo_stream_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_chip_select,
  output logic                   fifo_read_enable,
  fifo_stream_reader_if.master   out_stream,
  output logic [COUNT_WIDTH-1:0] words_out,
  output logic                   idle
);

  logic [DATA_WIDTH-1:0] buf_mem [3];
  logic [1:0]            wr_idx;
  logic [1:0]            rd_idx;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  pop;
  logic [2:0]            pending;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Every in-flight word already owns a buffer slot, so the buffer never overflows.
  assign pending          = {1'b0, occ} + {2'b00, inflight};
  assign fifo_read_enable = enable && !fifo_empty && (pending < 3'd3) && !reset;
  assign fifo_chip_select = fifo_read_enable;

  assign out_stream.out_valid = (occ != 2'd0);
  assign out_stream.out_data  = buf_mem[rd_idx];
  assign pop                  = out_stream.out_valid && out_stream.out_ready;
  assign idle                 = (occ == 2'd0) && !inflight;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight  <= 1'b0;
      wr_idx    <= 2'd0;
      rd_idx    <= 2'd0;
      occ       <= 2'd0;
      words_out <= '0;
    end else begin
      inflight <= fifo_read_enable;
      if (inflight) begin
        wr_idx <= next_idx(wr_idx);
      end
      if (pop) begin
        rd_idx    <= next_idx(rd_idx);
        words_out <= words_out + 1'b1;
      end
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // Data storage needs no reset; occ alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (inflight) begin
      buf_mem[wr_idx] <= fifo_data;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_data = 32'd0;
  logic        fifo_chip_select;
  logic        fifo_read_enable;
  logic [15:0] words_out;
  logic        idle;

  fifo_stream_reader_if #(.DATA_WIDTH(32)) s_if ();

  fifo_stream_reader #(.DATA_WIDTH(32), .COUNT_WIDTH(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .fifo_empty       (fifo_empty),
    .fifo_data        (fifo_data),
    .fifo_chip_select (fifo_chip_select),
    .fifo_read_enable (fifo_read_enable),
    .out_stream       (s_if.master),
    .words_out        (words_out),
    .idle             (idle)
  );

  always #5 clk = ~clk;

  // Behavioural synch_fifo: one-cycle read latency, empty flag reflects the last edge.
  logic [31:0] fifo_q [$];
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = 32'd0;

  always @(posedge clk) begin
    if (fifo_read_enable && fifo_chip_select && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
    if (wr_en) fifo_q.push_back(wr_data);
    fifo_empty <= (fifo_q.size() == 0);
  end

  int          cyc = 0;
  int          rd_log [$];
  logic [31:0] out_log [$];
  int          pop_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_read_enable) rd_log.push_back(cyc);
    if (s_if.out_valid && s_if.out_ready) begin
      out_log.push_back(s_if.out_data);
      pop_cyc.push_back(cyc);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fifo_write(input logic [31:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int max_cycles);
    int n = 0;
    while (!(idle && fifo_q.size() == 0) && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_timeout"}, 32'(n >= max_cycles), 32'd0);
  endtask

  int rb, ob, pb;

  initial begin
    s_if.out_ready = 1'b0;

    // Reset and idle with an empty FIFO
    cycles(2);
    check_eq("rst_rd_en", 32'(fifo_read_enable), 32'd0);
    check_eq("rst_valid", 32'(s_if.out_valid), 32'd0);
    check_eq("rst_idle", 32'(idle), 32'd1);
    check_eq("rst_words", 32'(words_out), 32'd0);
    reset = 1'b0;
    enable = 1'b1;
    s_if.out_ready = 1'b1;
    cycles(20);
    check_eq("idle_reads", 32'(rd_log.size()), 32'd0);
    check_eq("idle_valid", 32'(s_if.out_valid), 32'd0);
    check_eq("idle_idle", 32'(idle), 32'd1);
    check_eq("idle_words", 32'(words_out), 32'd0);

    // Basic drain
    rb = rd_log.size(); ob = out_log.size(); pb = pop_cyc.size();
    fifo_write(32'd1);
    fifo_write(32'd10);
    fifo_write(32'd100);
    wait_drain("drain", 40);
    check_eq("drain_count", 32'(out_log.size() - ob), 32'd3);
    check_eq("drain_w0", out_log[ob], 32'd1);
    check_eq("drain_w1", out_log[ob+1], 32'd10);
    check_eq("drain_w2", out_log[ob+2], 32'd100);
    check_eq("drain_latency", 32'(pop_cyc[pb] - rd_log[rb]), 32'd2);
    check_eq("drain_words", 32'(words_out), 32'd3);
    check_eq("drain_idle", 32'(idle), 32'd1);

    // Back-pressure
    s_if.out_ready = 1'b0;
    rb = rd_log.size(); ob = out_log.size(); pb = pop_cyc.size();
    fifo_write(32'd1);
    fifo_write(32'd2);
    fifo_write(32'd4);
    fifo_write(32'd8);
    cycles(5);
    check_eq("bp_data_early", s_if.out_data, 32'd1);
    cycles(5);
    check_eq("bp_reads", 32'(rd_log.size() - rb), 32'd3);
    check_eq("bp_valid", 32'(s_if.out_valid), 32'd1);
    check_eq("bp_data_late", s_if.out_data, 32'd1);
    check_eq("bp_fifo_left", 32'(fifo_q.size()), 32'd1);
    check_eq("bp_fifo_word", fifo_q[0], 32'd8);
    s_if.out_ready = 1'b1;
    wait_drain("bp", 40);
    check_eq("bp_count", 32'(out_log.size() - ob), 32'd4);
    check_eq("bp_w0", out_log[ob], 32'd1);
    check_eq("bp_w1", out_log[ob+1], 32'd2);
    check_eq("bp_w2", out_log[ob+2], 32'd4);
    check_eq("bp_w3", out_log[ob+3], 32'd8);
    check_eq("bp_b2b", 32'(pop_cyc[pb+3] - pop_cyc[pb]), 32'd3);
    check_eq("bp_words", 32'(words_out), 32'd7);

    // Throughput and index wrap, from a fresh reset
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    rb = rd_log.size(); ob = out_log.size(); pb = pop_cyc.size();
    for (int i = 0; i < 16; i++) fifo_write(32'(i));
    wait_drain("tp", 60);
    check_eq("tp_count", 32'(out_log.size() - ob), 32'd16);
    for (int i = 0; i < 16; i++) check_eq($sformatf("tp_w%0d", i), out_log[ob+i], 32'(i));
    check_eq("tp_out_span", 32'(pop_cyc[pb+15] - pop_cyc[pb]), 32'd15);
    check_eq("tp_rd_span", 32'(rd_log[rb+15] - rd_log[rb]), 32'd15);
    check_eq("tp_words", 32'(words_out), 32'd16);

    // Enable drops right after the edge that issues a read
    enable = 1'b0;
    rb = rd_log.size(); ob = out_log.size();
    fifo_write(32'd5);
    fifo_write(32'd6);
    fifo_write(32'd7);
    cycles(2);
    enable = 1'b1;
    cycles(1);
    enable = 1'b0;
    cycles(6);
    check_eq("en_reads", 32'(rd_log.size() - rb), 32'd1);
    check_eq("en_count", 32'(out_log.size() - ob), 32'd1);
    check_eq("en_w0", out_log[ob], 32'd5);
    check_eq("en_idle", 32'(idle), 32'd1);
    check_eq("en_fifo_left", 32'(fifo_q.size()), 32'd2);
    enable = 1'b1;
    wait_drain("en", 40);
    check_eq("en_count2", 32'(out_log.size() - ob), 32'd3);
    check_eq("en_w1", out_log[ob+1], 32'd6);
    check_eq("en_w2", out_log[ob+2], 32'd7);
    check_eq("en_words", 32'(words_out), 32'd19);

    // Reset with one read in flight and two words buffered
    s_if.out_ready = 1'b0;
    rb = rd_log.size(); ob = out_log.size();
    fifo_write(32'd11);
    fifo_write(32'd12);
    fifo_write(32'd13);
    fifo_write(32'd14);
    check_eq("mr_reads", 32'(rd_log.size() - rb), 32'd3);
    check_eq("mr_valid_pre", 32'(s_if.out_valid), 32'd1);
    check_eq("mr_idle_pre", 32'(idle), 32'd0);
    reset = 1'b1;
    #1;
    check_eq("mr_valid", 32'(s_if.out_valid), 32'd0);
    check_eq("mr_words", 32'(words_out), 32'd0);
    check_eq("mr_idle", 32'(idle), 32'd1);
    check_eq("mr_rd_en", 32'(fifo_read_enable), 32'd0);
    enable = 1'b0;
    cycles(2);
    reset = 1'b0;
    s_if.out_ready = 1'b1;
    cycles(4);
    check_eq("mr_stale_count", 32'(out_log.size() - ob), 32'd0);
    check_eq("mr_valid_after", 32'(s_if.out_valid), 32'd0);
    enable = 1'b1;
    wait_drain("mr", 40);
    check_eq("mr_count", 32'(out_log.size() - ob), 32'd1);
    check_eq("mr_w0", out_log[ob], 32'd14);
    check_eq("mr_words_after", 32'(words_out), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Drain stage that sits directly downstream of `synch_fifo`. It pulls words out of the FIFO through its chip-select/read-enable port, accounting for the FIFO's one-cycle read latency. It re-presents the words on a valid/ready stream so consumers never see the FIFO's latency or empty semantics. A 3-entry output buffer gives full throughput (one word per cycle) with no combinational path from `out_ready` to the FIFO controls.

## Interface
- `DATA_WIDTH`, default 32: word width; must match the FIFO's `data_size`.
- `COUNT_WIDTH`, default 16: width of the delivered-word counter.

- `clk` input 1: single clock; all state updates on posedge.
- `reset` input 1: asynchronous, active-high reset; clears all state immediately.
- `enable` input 1: when 1, the reader may issue FIFO reads; when 0, no new reads are issued.
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_data` input DATA_WIDTH: FIFO `data_out`; valid in the cycle after a read request.
- `fifo_chip_select` output 1: asserted together with `fifo_read_enable`; integration ORs it with the writer's select.
- `fifo_read_enable` output 1: one read request per cycle it is high.
- `out_valid` output 1: buffer head holds a word.
- `out_ready` input 1: consumer accepts the head word when `out_valid && out_ready`.
- `out_data` output DATA_WIDTH: buffer head word; holds stable while `out_valid && !out_ready`.
- `words_out` output COUNT_WIDTH: count of accepted output words; wraps modulo 2^COUNT_WIDTH.
- `idle` output 1: buffer empty and no read in flight.

## Operation
- State:
  - 3-entry circular buffer with 2-bit wrapping write and read indices (0→1→2→0).
  - `occ` (0..3): number of words held in the buffer.
  - `inflight` (1 bit): a read was issued last cycle.
  - `words_out` counter.
- Issue rule: `fifo_read_enable = enable && !fifo_empty && (occ + inflight) < 3 && !reset`. The rule uses registered state only.
- `fifo_chip_select = fifo_read_enable`.
- `inflight` next value = `fifo_read_enable`.
- Capture: when `inflight` is 1, `fifo_data` is written at the buffer write index on this posedge.
- Pop: `out_valid && out_ready` advances the read index and increments `words_out`.
- Occupancy update: `occ` next = `occ + inflight - pop`. A simultaneous capture and pop leaves `occ` unchanged.
- Outputs:
  - `out_valid = (occ != 0)`.
  - `out_data` = buffer entry at the read index.
  - `idle = (occ == 0) && !inflight`.
- Ordering: words leave in exactly the order the FIFO delivered them. No drops, no duplicates.
- Overflow: the buffer cannot overflow. The issue rule reserves a slot for every in-flight word.
- Upstream contract: `fifo_empty` must reflect a read accepted on the previous edge. The reader never issues a read while `fifo_empty` = 1, so it never captures an empty-FIFO result.
- `enable` falling: an in-flight word is still captured, and buffered words still drain. `idle` rises once both complete.
- Reset assertion at any time:
  - `occ` = 0, `inflight` = 0, indices = 0, `words_out` = 0.
  - Any word returning after reset release from a pre-reset read is ignored.

## Timing
- Reset values: `fifo_read_enable` 0, `fifo_chip_select` 0, `out_valid` 0, `out_data` = buffer entry 0 (don't-care), `words_out` 0, `idle` 1.
- Latency: `fifo_read_enable` high in cycle N → FIFO presents data in cycle N+1 → captured at the end of N+1 → `out_valid` high in cycle N+2.
- Empty FIFO with a first write landing: `fifo_empty` falls in cycle M, the read is issued in M, and `out_valid` is seen in M+2.
- Steady state with `out_ready` held at 1: one read per cycle and one output word per cycle.
- Back-pressure with `out_ready` = 0:
  - At most 3 words are buffered.
  - Reads stop when `occ + inflight` = 3.
  - Reads resume the cycle after the first pop lowers the sum.
- `words_out` updates at the same edge as the pop.

## Test plan
- Reset/idle:
  - Stimulus: assert `reset`, then release; hold `fifo_empty` = 1 for 20 cycles.
  - Required response: `fifo_read_enable` stays 0, `out_valid` 0, `idle` 1, `words_out` 0.
- Basic drain:
  - Stimulus: write 1, 10, 100 into the FIFO; `enable` = 1, `out_ready` = 1.
  - Required response: outputs are 1, 10, 100 in order; first `out_valid` two cycles after the first read; `words_out` = 3; then `idle` = 1.
- Back-pressure:
  - Stimulus: fill the FIFO with 1, 2, 4, 8; hold `out_ready` = 0 for 10 cycles.
  - Required response: exactly 3 reads issued; `out_data` = 1, stable; FIFO retains 8.
  - Stimulus: then set `out_ready` = 1.
  - Required response: 1, 2, 4, 8 delivered back-to-back.
- Throughput and wrap:
  - Stimulus: stream 0..15 through the FIFO with continuous writes and `out_ready` = 1.
  - Required response: 16 words in order, one per cycle in steady state; buffer indices wrap at least 5 times; `words_out` = 16.
- Enable gating:
  - Stimulus: deassert `enable` the same cycle a read is issued.
  - Required response: that word is still delivered; no further reads; `idle` rises.
  - Stimulus: reassert `enable`.
  - Required response: draining resumes with the next FIFO word.
- Reset mid-operation:
  - Stimulus: assert `reset` while `inflight` = 1 and `occ` = 2.
  - Required response: `out_valid` falls immediately, `words_out` = 0, and the returning stale word is not output.
